regfile_access_arbiter: RTL
===========================

Name: regfile_access_arbiter

Overview:
- Shares the register file's single valid/ready transaction port between NUM_REQ requesters, e.g. decode/writeback and the debug port.
- One transaction in flight at a time: accept one request, issue it to the register file, return its rs1/rs2 read data to the same requester, then re-arbitrate.
- Round-robin priority so no requester can starve another.
- Sits between the pipeline/debug front-ends and the register file.

Parameters:
- NUM_REQ, 2, number of requesters (≥1).
- IDX_W, $clog2(NUM_REQ) (min 1), width of grant index.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous, active-high reset
- req_valid_i  in  NUM_REQ  per-requester request valid
- req_ready_o  out  NUM_REQ  per-requester request accept
- req_rs1_addr_i  in  NUM_REQ*5  packed rs1 addresses, requester k at [5k+4:5k]
- req_rs2_addr_i  in  NUM_REQ*5  packed rs2 addresses
- req_rd_addr_i  in  NUM_REQ*5  packed rd addresses
- req_rd_data_i  in  NUM_REQ*32  packed write data
- req_wr_en_i  in  NUM_REQ  per-requester write enable
- rsp_valid_o  out  NUM_REQ  per-requester response valid
- rsp_ready_i  in  NUM_REQ  per-requester response accept
- rsp_rs1_data_o  out  32  rs1 read data, shared; qualified by rsp_valid_o
- rsp_rs2_data_o  out  32  rs2 read data, shared
- rf_valid_o  out  1  request valid to register file
- rf_ready_i  in  1  register file ready for request
- rf_rs1_addr_o, rf_rs2_addr_o, rf_rd_addr_o  out  5 each  latched request fields
- rf_rd_data_o  out  32  latched write data
- rf_wr_en_o  out  1  latched write enable
- rf_valid_i  in  1  register file read data valid
- rf_ready_o  out  1  accept of register file read data
- rf_rs1_data_i, rf_rs2_data_i  in  32 each  register file read data
- grant_o  out  IDX_W  index of the requester currently owning the transaction
- busy_o  out  1  high in any state other than IDLE

Behaviour:
- FSM states are IDLE, ISSUE, RESP.
- Reset (rst_i high at a clock edge) sets:
  - state to IDLE, priority pointer to 0, grant_o to 0, all latched rf_* fields to 0.
  - Outputs: req_ready_o=0, rsp_valid_o=0, rf_valid_o=0, rf_ready_o=0, busy_o=0.
  - Reset mid-transaction abandons the transaction without a response. Any write already accepted by the register file stands.
- IDLE:
  - Winner is the first requester with req_valid_i set, searching from the pointer upward with wrap (pointer, pointer+1, …, NUM_REQ-1, 0, …).
  - req_ready_o is one-hot on the winner and is combinational from req_valid_i. All other bits are 0; all are 0 if no request is valid.
  - On a handshake, the winner's fields are latched into rf_*, grant_o is set to the winner, and the next state is ISSUE.
- ISSUE:
  - rf_valid_o=1 with the latched fields held stable.
  - When rf_ready_i=1, the next state is RESP.
  - rf_valid_o must not drop before the handshake.
- RESP:
  - rf_ready_o = rsp_ready_i[grant_o].
  - rsp_valid_o[grant_o] = rf_valid_i; all other rsp_valid_o bits are 0.
  - rsp_rs1/rs2_data_o pass rf_rs1/rs2_data_i through combinationally.
  - When rf_valid_i and rsp_ready_i[grant_o] are both 1: next state is IDLE and the pointer becomes (grant_o+1) mod NUM_REQ.
- req_ready_o is 0 in ISSUE and RESP.
  - Requests raised there wait.
  - A requester may drop req_valid_i while unaccepted, with no effect.
- The pointer advances only on response completion, never on acceptance.
- The cycle after a response completes is always IDLE, so there is a one-cycle bubble and no back-to-back accept in the completion cycle.
- Minimum transaction time is 3 cycles: accept, issue, response.
- Fields pass through unmodified: wr_en with rd_addr=0 is forwarded, and the register file drops it.
- NUM_REQ=1: pointer is always 0 and the block behaves as a single-entry pass-through.
- Outputs are stable whenever their valid is held and the corresponding ready is low.

Test Plan:
1. Reset then single request: req0 valid with rs1=3, rs2=5, rd=7, wr_en=1, data=0xDEADBEEF.
   - Required: req_ready_o=2'b01 in cycle 0; rf_valid_o=1 with those fields in cycle 1.
   - Register file returns rs1/rs2 data 0x11/0x22 → rsp_valid_o=2'b01 with data 0x11/0x22; busy_o=0 after completion.
2. Simultaneous req0 and req1 held continuously for 4 transactions.
   - Required: grant_o sequence 0,1,0,1; each transaction ≥3 cycles plus one IDLE bubble.
3. rf_ready_i held low for 5 cycles in ISSUE.
   - Required: rf_valid_o stays 1 and fields are unchanged; state advances to RESP on the cycle rf_ready_i rises.
4. Response backpressure: rf_valid_i=1, rsp_ready_i[grant]=0 for 3 cycles.
   - Required: rf_ready_o=0, rsp_valid_o stays asserted, no completion; completion occurs when rsp_ready_i rises.
5. rst_i asserted in RESP.
   - Required: next cycle state IDLE, rsp_valid_o=0, rf_valid_o=0, grant_o=0, pointer 0; a pending req1 is re-arbitrated from index 0.
6. Write to rd=0 with wr_en=1, data=0x5.
   - Required: forwarded unchanged as rf_rd_addr_o=0, rf_wr_en_o=1; a subsequent read of x0 returns 0.

Source files
------------

// File: rtl/regfile_access_arbiter.sv
// Round-robin arbiter sharing the register file's single valid/ready port among
// NUM_REQ requesters; one transaction (accept, issue, response) in flight at a time.
module regfile_access_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [NUM_REQ-1:0]      req_valid_i,
    output logic [NUM_REQ-1:0]      req_ready_o,
    input  logic [NUM_REQ*5-1:0]    req_rs1_addr_i,
    input  logic [NUM_REQ*5-1:0]    req_rs2_addr_i,
    input  logic [NUM_REQ*5-1:0]    req_rd_addr_i,
    input  logic [NUM_REQ*32-1:0]   req_rd_data_i,
    input  logic [NUM_REQ-1:0]      req_wr_en_i,
    output logic [NUM_REQ-1:0]      rsp_valid_o,
    input  logic [NUM_REQ-1:0]      rsp_ready_i,
    output logic [31:0]             rsp_rs1_data_o,
    output logic [31:0]             rsp_rs2_data_o,
    output logic                    rf_valid_o,
    input  logic                    rf_ready_i,
    output logic [4:0]              rf_rs1_addr_o,
    output logic [4:0]              rf_rs2_addr_o,
    output logic [4:0]              rf_rd_addr_o,
    output logic [31:0]             rf_rd_data_o,
    output logic                    rf_wr_en_o,
    input  logic                    rf_valid_i,
    output logic                    rf_ready_o,
    input  logic [31:0]             rf_rs1_data_i,
    input  logic [31:0]             rf_rs2_data_i,
    output logic [IDX_W-1:0]        grant_o,
    output logic                    busy_o
);
    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    state_t           state, state_nxt;
    logic [IDX_W-1:0] ptr, grant, win;
    logic             found, accept, rsp_done;
    logic [4:0]       rs1_q, rs2_q, rd_q;
    logic [31:0]      data_q;
    logic             we_q;

    // Search from the pointer upward with wrap; first valid requester wins.
    always_comb begin
        int j;
        found = 1'b0;
        win   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            j = int'(ptr) + i;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            if (!found && req_valid_i[j]) begin
                found = 1'b1;
                win   = IDX_W'(j);
            end
        end
    end

    // No accept while reset is asserted, so a requester never sees a lost handshake.
    assign accept   = (state == IDLE) && found && !rst_i;
    assign rsp_done = (state == RESP) && rf_valid_i && rsp_ready_i[grant];

    always_ff @(posedge clk_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (found)      state_nxt = ISSUE;
            ISSUE:   if (rf_ready_i) state_nxt = RESP;
            RESP:    if (rsp_done)   state_nxt = IDLE;
            default:                 state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ready_o = '0;
        rsp_valid_o = '0;
        rf_valid_o  = 1'b0;
        rf_ready_o  = 1'b0;
        case (state)
            IDLE:  if (accept) req_ready_o[win] = 1'b1;
            ISSUE: rf_valid_o = 1'b1;
            RESP: begin
                rf_ready_o         = rsp_ready_i[grant];
                rsp_valid_o[grant] = rf_valid_i;
            end
            default: ;
        endcase
    end

    // Pointer moves only when a response completes, never on acceptance.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr    <= '0;
            grant  <= '0;
            rs1_q  <= '0;
            rs2_q  <= '0;
            rd_q   <= '0;
            data_q <= '0;
            we_q   <= 1'b0;
        end else begin
            if (accept) begin
                grant  <= win;
                rs1_q  <= req_rs1_addr_i[5*win +: 5];
                rs2_q  <= req_rs2_addr_i[5*win +: 5];
                rd_q   <= req_rd_addr_i[5*win +: 5];
                data_q <= req_rd_data_i[32*win +: 32];
                we_q   <= req_wr_en_i[win];
            end
            if (rsp_done)
                ptr <= (grant == IDX_W'(NUM_REQ-1)) ? '0 : grant + 1'b1;
        end
    end

    assign rf_rs1_addr_o  = rs1_q;
    assign rf_rs2_addr_o  = rs2_q;
    assign rf_rd_addr_o   = rd_q;
    assign rf_rd_data_o   = data_q;
    assign rf_wr_en_o     = we_q;
    assign rsp_rs1_data_o = rf_rs1_data_i;
    assign rsp_rs2_data_o = rf_rs2_data_i;
    assign grant_o        = grant;
    assign busy_o         = (state != IDLE);
endmodule
